vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates VGA raster timing for the game display: divides the 100 MHz board clock down to the pixel rate, runs the horizontal/vertical pixel counters, and drives HS/VS. It is the producer of hor_pix/ver_pix consumed by the sprite/background renderers. It also takes the renderers' 4-bit colour channels back in, blanks them outside the active area, and drives the board's 12-bit vgaRGB.

Parameters:
WIDTH, 10, bit width of hor_pix/ver_pix; must satisfy H_TOTAL <= 2^WIDTH and V_TOTAL <= 2^WIDTH
CLK_DIV, 4, clk cycles per pixel; even, >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of HS/VS (0 = active-low)

Ports:
clk  in  1  board clock, 100 MHz
rst  in  1  asynchronous, active-high reset
vgaRed  in  4  renderer red channel for the current pixel
vgaGreen  in  4  renderer green channel
vgaBlue  in  4  renderer blue channel
pixel_clock  out  1  divided clock, 50% duty, period CLK_DIV clk cycles
pixel_tick  out  1  one-clk strobe, once per pixel period
hor_pix  out  WIDTH  current horizontal coordinate, 0..H_TOTAL-1
ver_pix  out  WIDTH  current vertical coordinate, 0..V_TOTAL-1
video_on  out  1  high when hor_pix < H_ACTIVE and ver_pix < V_ACTIVE
line_start  out  1  one-clk strobe when hor_pix wraps to 0
frame_start  out  1  one-clk strobe when both counters wrap to (0,0)
HS  out  1  horizontal sync
VS  out  1  vertical sync
vgaRGB  out  12  {R,G,B} to the connector, blanked

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is the same sum of the V_* parameters (525).
- All outputs are registered. Reset values:
  - div_cnt=0, pixel_clock=0, pixel_tick=0
  - hor_pix=0, ver_pix=0, video_on=1
  - line_start=0, frame_start=0, vgaRGB=0
  - HS=VS=~SYNC_POL (deasserted)
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick=1 on the clk cycle where div_cnt==CLK_DIV-1, else 0.
  - pixel_clock=1 while div_cnt >= CLK_DIV/2, registered.
  - The first pixel_tick occurs CLK_DIV cycles after reset release.
- Counters advance only on the edge where pixel_tick is high:
  - hor_pix increments; at H_TOTAL-1 it wraps to 0 and ver_pix increments.
  - At ver_pix==V_TOTAL-1 with a horizontal wrap, ver_pix wraps to 0.
- HS, VS and video_on are computed from the next counter values and update on the same edge as the counters, so they are always consistent with the visible hor_pix/ver_pix.
  - HS = SYNC_POL when H_ACTIVE+H_FP <= hor_pix < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - VS = SYNC_POL when V_ACTIVE+V_FP <= ver_pix < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL. VS changes only at horizontal wrap.
- line_start is high for exactly one clk, on the edge where hor_pix becomes 0.
- frame_start is high for exactly one clk, on the edge where (hor_pix,ver_pix) becomes (0,0). It coincides with line_start.
- Colour path:
  - On each pixel_tick edge: vgaRGB <= video_on ? {vgaRed,vgaGreen,vgaBlue} : 12'h000.
  - video_on here is the value before the update, so the sample corresponds to the coordinate just displayed.
  - Latency from coordinate presentation to vgaRGB is one pixel period. Renderers must produce colour within CLK_DIV-1 clk cycles of a coordinate change.
  - vgaRGB holds between ticks.
- Arithmetic:
  - Comparisons use WIDTH-bit unsigned values.
  - Counters never exceed H_TOTAL-1 or V_TOTAL-1; no other wrap path exists.
- Reset asserted mid-frame immediately forces all reset values, with no wait for a tick. Counting restarts from (0,0) on release; no partial-line output.

Test Plan:
- Reset then release -> all outputs at reset values (HS=VS=1, vgaRGB=0). First pixel_tick at clk 4 after release. pixel_clock toggles every 2 clk. hor_pix=1 after the first tick.
- Run one line -> HS=0 for exactly hor_pix 656..751 (96 ticks = 384 clk), 1 elsewhere. Then 799->0 wrap: ver_pix 0->1, line_start a single 1-clk pulse.
- Run a full frame -> VS=0 exactly on lines 490..491 (1600 ticks). After ver 524/hor 799, counters return to (0,0) with frame_start and line_start both pulsed for one clk. Frame period is 420000 pixels = 1680000 clk.
- Drive vgaRed/Green/Blue=F,F,F continuously -> vgaRGB=12'hFFF for coordinates hor 0..639 and ver 0..479. vgaRGB=12'h000 for hor 640..799 and ver 480..524. The transition lags video_on by one pixel period.
- Drive 12'hA5C at (100,50) only -> vgaRGB=12'hA5C during the pixel period after the tick that leaves (100,50). Surrounding pixels carry their own inputs.
- Assert rst at hor 300/ver 200 mid-divider -> outputs immediately reset: hor/ver=0, HS=VS=1, vgaRGB=0. After release, timing matches the post-reset scenario exactly.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters,
// sync generation and blanking of the renderer colour channels.
module vga_timing_gen #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       vgaRed,
  input  logic [3:0]       vgaGreen,
  input  logic [3:0]       vgaBlue,
  output logic             pixel_clock,
  output logic             pixel_tick,
  output logic [WIDTH-1:0] hor_pix,
  output logic [WIDTH-1:0] ver_pix,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             HS,
  output logic             VS,
  output logic [11:0]      vgaRGB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned XW      = WIDTH + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [WIDTH-1:0] H_LAST   = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_LAST   = WIDTH'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so a sync pulse ending exactly at
  // 2^WIDTH still compares correctly.
  localparam logic [XW-1:0] H_ACT_E = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] V_ACT_E = XW'(V_ACTIVE);
  localparam logic [XW-1:0] VS_BEG  = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0] VS_END  = XW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [WIDTH-1:0] hor_nxt;
  logic [WIDTH-1:0] ver_nxt;
  logic [XW-1:0]    hor_ext;
  logic [XW-1:0]    ver_ext;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             on_nxt;

  // Next divider count, wrapping at CLK_DIV-1.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Next raster position, applied only on a pixel tick.
  always_comb begin
    h_wrap  = (hor_pix == H_LAST);
    v_wrap  = h_wrap && (ver_pix == V_LAST);
    hor_nxt = h_wrap ? '0 : hor_pix + 1'b1;
    ver_nxt = ver_pix;
    if (h_wrap) begin
      ver_nxt = (ver_pix == V_LAST) ? '0 : ver_pix + 1'b1;
    end
  end

  // Sync and active-area decode of the next position, so the registered
  // flags line up with the registered coordinates.
  always_comb begin
    hor_ext = {1'b0, hor_nxt};
    ver_ext = {1'b0, ver_nxt};
    hs_nxt  = ((hor_ext >= HS_BEG) && (hor_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt  = ((ver_ext >= VS_BEG) && (ver_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
    on_nxt  = (hor_ext < H_ACT_E) && (ver_ext < V_ACT_E);
  end

  // Clock divider: count, tick strobe and 50% duty pixel clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      pixel_tick  <= 1'b0;
      pixel_clock <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pixel_tick  <= (div_nxt == DIV_LAST);
      pixel_clock <= (div_nxt >= DIV_HALF);
    end
  end

  // Raster counters, sync/strobe outputs and colour capture on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hor_pix     <= '0;
      ver_pix     <= '0;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      HS          <= ~SYNC_POL;
      VS          <= ~SYNC_POL;
      vgaRGB      <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        hor_pix     <= hor_nxt;
        ver_pix     <= ver_nxt;
        HS          <= hs_nxt;
        VS          <= vs_nxt;
        video_on    <= on_nxt;
        line_start  <= h_wrap;
        frame_start <= v_wrap;
        // Uses the pre-update video_on: the sample belongs to the pixel
        // that was on screen during the period just ending.
        vgaRGB      <= video_on ? {vgaRed, vgaGreen, vgaBlue} : '0;
      end
    end
  end

endmodule
